// File: rtl/meduram_pkg.sv
// Shared types and helpers for the LVT-based multi-port RAM.
// Packed-bus slicing and live-value-table index type.
package meduram_pkg;

  localparam int MAX_NB_WR = 4;
  localparam int MAX_NB_RD = 8;

  typedef logic [$clog2(MAX_NB_WR)-1:0] lvt_idx_t;

  function automatic int port_slice(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/meduram_bank.sv
// Simple 1W1R synchronous bank, no reset.
// Read register updates only on re, so it holds between reads.
module meduram_bank #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/meduram_lvt.sv
// Multi-port RAM from NB_WR x NB_RD banks plus a live value table.
// Lowest write port wins address collisions.
module meduram_lvt
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_WR        = 2,
  parameter int NB_RD        = 2,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NB_WR-1:0]            wren,
  input  logic [NB_WR*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_WR*DATA_WIDTH-1:0] wrdata,
  input  logic [NB_RD-1:0]            rden,
  input  logic [NB_RD*ADDR_WIDTH-1:0] rdaddr,
  output logic [NB_RD*DATA_WIDTH-1:0] rddata,
  output logic [NB_RD-1:0]            rdvalid,
  output logic [NB_WR-1:0]            wrcollision
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [AW-1:0] wa [NB_WR];
  logic [DW-1:0] wd [NB_WR];
  logic [AW-1:0] ra [NB_RD];
  logic [NB_WR-1:0] wok, win;
  logic [NB_RD-1:0] rinr, rok, byp;
  logic [DW-1:0] bypd [NB_RD];
  logic [DW-1:0] bq [NB_WR][NB_RD];

  lvt_idx_t lvt [RAM_DEPTH];

  always_comb begin
    for (int i = 0; i < NB_WR; i++) begin
      wa[i]  = wraddr[port_slice(i, AW) +: AW];
      wd[i]  = wrdata[port_slice(i, DW) +: DW];
      wok[i] = wren[i] && (int'(wa[i]) < RAM_DEPTH);
    end
    for (int i = 0; i < NB_WR; i++) begin
      win[i] = wok[i];
      for (int k = 0; k < NB_WR; k++)
        if (k < i && wok[k] && wa[k] == wa[i]) win[i] = 1'b0;
    end
  end

  // Only one winner can remain per address, so the bypass pick is unique.
  always_comb begin
    for (int j = 0; j < NB_RD; j++) begin
      ra[j]   = rdaddr[port_slice(j, AW) +: AW];
      rinr[j] = int'(ra[j]) < RAM_DEPTH;
      rok[j]  = rden[j] && rinr[j];
      byp[j]  = 1'b0;
      bypd[j] = '0;
      if (WRITE_FIRST != 0)
        for (int i = 0; i < NB_WR; i++)
          if (win[i] && wa[i] == ra[j]) begin
            byp[j]  = 1'b1;
            bypd[j] = wd[i];
          end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int d = 0; d < RAM_DEPTH; d++) lvt[d] <= '0;
    end else begin
      for (int i = 0; i < NB_WR; i++)
        if (win[i]) lvt[wa[i]] <= lvt_idx_t'(i);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wrcollision <= '0;
    else          wrcollision <= wok & ~win;
  end

  for (genvar gi = 0; gi < NB_WR; gi++) begin : g_wr
    for (genvar gj = 0; gj < NB_RD; gj++) begin : g_rd
      meduram_bank #(.AW(AW), .DW(DW), .DEPTH(RAM_DEPTH)) u_bank (
        .clk   (aclk),
        .we    (win[gi]),
        .waddr (wa[gi]),
        .wdata (wd[gi]),
        .re    (rok[gj]),
        .raddr (ra[gj]),
        .rdata (bq[gi][gj])
      );
    end
  end

  lvt_idx_t      sel_q  [NB_RD];
  logic [DW-1:0] bypd_q [NB_RD];
  logic [DW-1:0] rd1    [NB_RD];
  logic [NB_RD-1:0] v1, zero_q, byp_q;

  // Stage-1 side info tracks the bank read register; zero_q masks stale bank data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1     <= '0;
      zero_q <= '1;
      byp_q  <= '0;
      for (int j = 0; j < NB_RD; j++) begin
        sel_q[j]  <= '0;
        bypd_q[j] <= '0;
      end
    end else begin
      v1 <= rden;
      for (int j = 0; j < NB_RD; j++)
        if (rden[j]) begin
          sel_q[j]  <= rinr[j] ? lvt[ra[j]] : '0;
          zero_q[j] <= !rinr[j];
          byp_q[j]  <= byp[j];
          bypd_q[j] <= bypd[j];
        end
    end
  end

  always_comb begin
    for (int j = 0; j < NB_RD; j++) begin
      rd1[j] = '0;
      if (!zero_q[j]) rd1[j] = byp_q[j] ? bypd_q[j] : bq[sel_q[j]][j];
    end
  end

  logic [DW-1:0] rdo [NB_RD];

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DW-1:0] rd2 [NB_RD];
    logic [NB_RD-1:0] v2;
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        v2 <= '0;
        for (int j = 0; j < NB_RD; j++) rd2[j] <= '0;
      end else begin
        v2 <= v1;
        for (int j = 0; j < NB_RD; j++)
          if (v1[j]) rd2[j] <= rd1[j];
      end
    end
    assign rdvalid = v2;
    assign rdo     = rd2;
  end else begin : g_lat1
    assign rdvalid = v1;
    assign rdo     = rd1;
  end

  always_comb begin
    rddata = '0;
    for (int j = 0; j < NB_RD; j++)
      rddata[port_slice(j, DW) +: DW] = rdo[j];
  end

`ifdef FORMAL
  for (genvar gj = 0; gj < NB_RD; gj++) begin : g_fv
    a_rd_range: assert property (@(posedge aclk) disable iff (!aresetn)
      rden[gj] |-> rinr[gj]);
  end
`endif

endmodule

// File: tb/tb_meduram_lvt.sv
// Directed bench for meduram_lvt: u0 is latency 1 read-old,
// u1 is latency 2 write-first, both driven by the same stimulus.
module tb_meduram_lvt;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  wren;
  logic [15:0] wraddr;
  logic [63:0] wrdata;
  logic [1:0]  rden;
  logic [15:0] rdaddr;
  logic [63:0] rddata0, rddata1;
  logic [1:0]  rdvalid0, rdvalid1, wrcol0, wrcol1;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BASE = 32'h5000_0000;

  always #5 aclk = ~aclk;

  meduram_lvt #(.READ_LATENCY(1), .WRITE_FIRST(0)) u0 (
    .aclk(aclk), .aresetn(aresetn), .wren(wren), .wraddr(wraddr),
    .wrdata(wrdata), .rden(rden), .rdaddr(rdaddr), .rddata(rddata0),
    .rdvalid(rdvalid0), .wrcollision(wrcol0)
  );

  meduram_lvt #(.READ_LATENCY(2), .WRITE_FIRST(1)) u1 (
    .aclk(aclk), .aresetn(aresetn), .wren(wren), .wraddr(wraddr),
    .wrdata(wrdata), .rden(rden), .rdaddr(rdaddr), .rddata(rddata1),
    .rdvalid(rdvalid1), .wrcollision(wrcol1)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    wren = '0; wraddr = '0; wrdata = '0; rden = '0; rdaddr = '0;
  endtask

  initial begin
    aresetn = 1'b0;
    idle();

    // 1: reset
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_v0", 64'(rdvalid0), 64'd0);
      chk("rst_v1", 64'(rdvalid1), 64'd0);
      chk("rst_d0", rddata0, 64'd0);
      chk("rst_d1", rddata1, 64'd0);
      chk("rst_c0", 64'(wrcol0), 64'd0);
      chk("rst_c1", 64'(wrcol1), 64'd0);
    end
    aresetn = 1'b1;
    tick();
    chk("rel_v0", 64'(rdvalid0), 64'd0);
    chk("rel_d0", rddata0, 64'd0);
    chk("rel_c0", 64'(wrcol0), 64'd0);

    // 2: separate writes, crossed reads
    wren = 2'b11; wraddr = {8'h20, 8'h10};
    wrdata = {32'h2222_2222, 32'h1111_1111};
    tick();
    chk("sep_c0", 64'(wrcol0), 64'd0);
    idle();
    rden = 2'b11; rdaddr = {8'h10, 8'h20};
    tick();
    chk("sep_d0", rddata0, {32'h1111_1111, 32'h2222_2222});
    chk("sep_v0", 64'(rdvalid0), 64'd3);
    chk("sep_v1_early", 64'(rdvalid1), 64'd0);
    idle();
    tick();
    chk("sep_d1", rddata1, {32'h1111_1111, 32'h2222_2222});
    chk("sep_v1", 64'(rdvalid1), 64'd3);
    chk("sep_v0_off", 64'(rdvalid0), 64'd0);
    chk("sep_d0_hold", rddata0, {32'h1111_1111, 32'h2222_2222});

    // 3: collision on 0x05
    wren = 2'b11; wraddr = {8'h05, 8'h05};
    wrdata = {32'hBBBB_0000, 32'hAAAA_0000};
    tick();
    idle();
    chk("col_c0", 64'(wrcol0), 64'd2);
    chk("col_c1", 64'(wrcol1), 64'd2);
    rden = 2'b01; rdaddr = {8'h00, 8'h05};
    tick();
    chk("col_c0_clr", 64'(wrcol0), 64'd0);
    chk("col_rd0", 64'(rddata0[31:0]), 64'hAAAA_0000);
    idle();
    tick();
    chk("col_rd1", 64'(rddata1[31:0]), 64'hAAAA_0000);

    // 4: read during write
    wren = 2'b10; wraddr = {8'h05, 8'h00}; wrdata = {32'hCCCC_0000, 32'h0};
    rden = 2'b01; rdaddr = {8'h00, 8'h05};
    tick();
    idle();
    chk("rdw_old0", 64'(rddata0[31:0]), 64'hAAAA_0000);
    chk("rdw_c0", 64'(wrcol0), 64'd0);
    tick();
    chk("rdw_new1", 64'(rddata1[31:0]), 64'hCCCC_0000);
    rden = 2'b01; rdaddr = {8'h00, 8'h05};
    tick();
    idle();
    chk("rdw_next0", 64'(rddata0[31:0]), 64'hCCCC_0000);
    tick();
    chk("rdw_next1", 64'(rddata1[31:0]), 64'hCCCC_0000);

    // 5: fill 0..15 (port0 even, port1 odd) then stream
    for (int a = 0; a < 8; a++) begin
      wren   = 2'b11;
      wraddr = {8'(2*a+1), 8'(2*a)};
      wrdata = {BASE + 32'(2*a+1), BASE + 32'(2*a)};
      tick();
    end
    idle();
    for (int c = 0; c < 18; c++) begin
      rden   = (c < 16) ? 2'b01 : 2'b00;
      rdaddr = {8'h00, 8'(c)};
      tick();
      chk("str_v1", 64'(rdvalid1[0]), 64'((c >= 1 && c <= 16) ? 1 : 0));
      if (c >= 1 && c <= 16)
        chk("str_d1", 64'(rddata1[31:0]), 64'(BASE + 32'(c-1)));
      chk("str_v0", 64'(rdvalid0[0]), 64'((c < 16) ? 1 : 0));
      if (c < 16)
        chk("str_d0", 64'(rddata0[31:0]), 64'(BASE + 32'(c)));
    end
    idle();

    // 6: reset with reads in flight
    rden = 2'b11; rdaddr = {8'h01, 8'h00};
    tick();
    chk("mid_v0_pre", 64'(rdvalid0), 64'd3);
    chk("mid_v1_pre", 64'(rdvalid1), 64'd0);
    idle();
    aresetn = 1'b0;
    #1;
    chk("mid_v0", 64'(rdvalid0), 64'd0);
    chk("mid_v1", 64'(rdvalid1), 64'd0);
    chk("mid_d0", rddata0, 64'd0);
    tick();
    chk("mid_v1_next", 64'(rdvalid1), 64'd0);
    chk("mid_d1_next", rddata1, 64'd0);
    aresetn = 1'b1;
    tick();

    // LVT cleared: 0x05 now resolves to port-0 banks, last written with 0xAAAA0000
    rden = 2'b01; rdaddr = {8'h00, 8'h05};
    tick();
    idle();
    chk("lvt_rst_d0", 64'(rddata0[31:0]), 64'hAAAA_0000);
    tick();
    chk("lvt_rst_d1", 64'(rddata1[31:0]), 64'hAAAA_0000);
    chk("lvt_rst_v1", 64'(rdvalid1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
